// File: rtl/ex_pkg.sv
// ex_pkg: shared opcode encoding, divider cycle count and EX/MEM bubble field values.
// Contents: op_e opcode enum, MD_DIV_CYCLES, BUBBLE_* control values.
package ex_pkg;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
    } op_e;
    localparam int MD_DIV_CYCLES = 33;
    localparam logic BUBBLE_REG_WRITE = 1'b0;
    localparam logic BUBBLE_MEM_READ = 1'b0;
    localparam logic BUBBLE_MEM_WRITE = 1'b0;
endpackage

// File: rtl/ex_if.sv
// ex_if: EX stage bus bundling the ID/EX inputs and the EX/MEM register outputs.
// master: drives in_valid/flush/op/a/b/shamt/imm_lu and *_in fields, observes outputs.
// slave:  the EX stage; drives ALU_S..LUData, stall and md_busy.
interface ex_if;
    import ex_pkg::*;
    logic in_valid, flush;
    op_e op;
    logic [31:0] a, b, imm_lu;
    logic [4:0] shamt;
    logic [31:0] mem_wdata_in, pc_plus4_in;
    logic [4:0] wreg_in;
    logic mem_read_in, mem_write_in, reg_write_in, lu_op_in;
    logic [1:0] mem_to_reg_in;
    logic [31:0] ALU_S, MemWriteData, PC_Plus4, LUData;
    logic [4:0] WriteReg;
    logic MemRead, MemWrite, RegWrite, LUOp;
    logic [1:0] MemToReg;
    logic stall, md_busy;
    modport master (
        output in_valid, flush, op, a, b, imm_lu, shamt, mem_wdata_in, pc_plus4_in,
               wreg_in, mem_read_in, mem_write_in, reg_write_in, lu_op_in, mem_to_reg_in,
        input  ALU_S, MemWriteData, PC_Plus4, LUData, WriteReg, MemRead, MemWrite,
               RegWrite, LUOp, MemToReg, stall, md_busy
    );
    modport slave (
        input  in_valid, flush, op, a, b, imm_lu, shamt, mem_wdata_in, pc_plus4_in,
               wreg_in, mem_read_in, mem_write_in, reg_write_in, lu_op_in, mem_to_reg_in,
        output ALU_S, MemWriteData, PC_Plus4, LUData, WriteReg, MemRead, MemWrite,
               RegWrite, LUOp, MemToReg, stall, md_busy
    );
endinterface

// File: rtl/ex_divider.sv
// ex_divider: radix-2 restoring divider on magnitudes, result valid MD_DIV_CYCLES after start.
// Ports: clk, reset (async high); start_i/signed_i/a_i/b_i launch a divide;
// done_o pulses for one cycle with quo_o/rem_o valid, the edge that ends it is the 33rd after start.
module ex_divider import ex_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);
    logic busy_q, qneg_q, rneg_q;
    logic [5:0] cnt_q;
    logic [31:0] quo_q, rem_q, den_q, dvd_q;
    logic [32:0] trial, diff;
    logic ge, a_neg, b_neg;
    assign a_neg = signed_i & a_i[31];
    assign b_neg = signed_i & b_i[31];
    // quo_q starts as the dividend magnitude and shifts quotient bits in from the right
    assign trial = {rem_q, quo_q[31]};
    assign diff = trial - {1'b0, den_q};
    assign ge = ~diff[32];
    assign done_o = busy_q & (cnt_q == 6'(MD_DIV_CYCLES - 1));
    // divide-by-zero is overridden; remainder follows the dividend's sign
    assign quo_o = (den_q == 32'd0) ? '1 : qneg_q ? -quo_q : quo_q;
    assign rem_o = (den_q == 32'd0) ? dvd_q : rneg_q ? -rem_q : rem_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            dvd_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q <= '0;
            quo_q <= a_neg ? -a_i : a_i;
            rem_q <= '0;
            den_q <= b_neg ? -b_i : b_i;
            dvd_q <= a_i;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (busy_q) begin
            if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 6'd1;
                quo_q <= {quo_q[30:0], ge};
                rem_q <= ge ? diff[31:0] : trial[31:0];
            end
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS-style execute stage with ALU, HI/LO, multi-cycle multiply and optional divide.
// Ports: clk, reset (async high), e (ex_if.slave: ID/EX inputs, EX/MEM outputs, stall, md_busy).
// Parameter MUL_LAT (1..4): cycles from MULT acceptance to HI/LO write.
// Macro EX_DIV_EN: builds the iterative divider; otherwise DIV/DIVU are bubbles with no effect.
module ex_stage import ex_pkg::*; #(
    parameter int MUL_LAT = 2
) (
    input logic clk,
    input logic reset,
    ex_if.slave e
);
    logic is_mul, is_div, is_mf, is_mt, is_md, acc, go, bubble, md_wr;
    logic md_busy_q, md_div_q, mul_sg_q;
    logic [1:0] md_cnt_q;
    logic [31:0] hi_q, lo_q, hi_d, lo_d, alu, mul_a_q, mul_b_q;
    logic [63:0] prod;
    assign is_mul = (e.op == OP_MULT) || (e.op == OP_MULTU);
    assign is_div = (e.op == OP_DIV) || (e.op == OP_DIVU);
    assign is_mf = (e.op == OP_MFHI) || (e.op == OP_MFLO);
    assign is_mt = (e.op == OP_MTHI) || (e.op == OP_MTLO);
`ifdef EX_DIV_EN
    logic div_done;
    logic [31:0] div_quo, div_rem;
    assign is_md = is_mul | is_div;
    ex_divider u_div (
        .clk(clk),
        .reset(reset),
        .start_i(acc & is_div),
        .signed_i(e.op == OP_DIV),
        .a_i(e.a),
        .b_i(e.b),
        .done_o(div_done),
        .quo_o(div_quo),
        .rem_o(div_rem)
    );
`else
    assign is_md = is_mul;
`endif
    assign acc = e.in_valid & ~e.flush & ~md_busy_q & is_md;
    assign e.stall = md_busy_q & e.in_valid & (is_mf | is_mt | is_mul | is_div);
    assign e.md_busy = md_busy_q;
    assign go = e.in_valid & ~e.flush & ~e.stall;
    // MD ops never write a GPR from EX, so they always leave a bubble behind
    assign bubble = ~go | is_mul | is_div;
    // sign-extending to 64 bits lets one multiplier serve both MULT and MULTU
    assign prod = {{32{mul_sg_q & mul_a_q[31]}}, mul_a_q} * {{32{mul_sg_q & mul_b_q[31]}}, mul_b_q};
    always_comb begin
        md_wr = md_busy_q & ~md_div_q & (md_cnt_q == 2'd0);
        hi_d = prod[63:32];
        lo_d = prod[31:0];
`ifdef EX_DIV_EN
        if (div_done) begin
            md_wr = 1'b1;
            hi_d = div_rem;
            lo_d = div_quo;
        end
`endif
        // completion outranks MTHI/MTLO; MT* is stalled while busy in any case
        if (!md_wr) begin
            hi_d = (go && e.op == OP_MTHI) ? e.a : hi_q;
            lo_d = (go && e.op == OP_MTLO) ? e.a : lo_q;
        end
    end
    always_comb begin
        alu = e.a;
        case (e.op)
            OP_ADD:  alu = e.a + e.b;
            OP_SUB:  alu = e.a - e.b;
            OP_AND:  alu = e.a & e.b;
            OP_OR:   alu = e.a | e.b;
            OP_XOR:  alu = e.a ^ e.b;
            OP_NOR:  alu = ~(e.a | e.b);
            OP_SLT:  alu = {31'd0, $signed(e.a) < $signed(e.b)};
            OP_SLTU: alu = {31'd0, e.a < e.b};
            OP_SLL:  alu = e.a << e.shamt;
            OP_SRL:  alu = e.a >> e.shamt;
            OP_SRA:  alu = $signed(e.a) >>> e.shamt;
            OP_SLLV: alu = e.a << e.b[4:0];
            OP_SRLV: alu = e.a >> e.b[4:0];
            OP_SRAV: alu = $signed(e.a) >>> e.b[4:0];
            OP_MFHI: alu = hi_q;
            OP_MFLO: alu = lo_q;
            default: alu = e.a;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_busy_q <= 1'b0;
            md_div_q <= 1'b0;
            md_cnt_q <= '0;
            mul_sg_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            e.ALU_S <= '0;
            e.MemWriteData <= '0;
            e.WriteReg <= '0;
            e.MemRead <= 1'b0;
            e.MemWrite <= 1'b0;
            e.RegWrite <= 1'b0;
            e.MemToReg <= '0;
            e.PC_Plus4 <= '0;
            e.LUOp <= 1'b0;
            e.LUData <= '0;
        end else begin
            if (acc) begin
                md_busy_q <= 1'b1;
                md_div_q <= is_div;
                md_cnt_q <= 2'(MUL_LAT - 1);
                mul_sg_q <= e.op == OP_MULT;
                mul_a_q <= e.a;
                mul_b_q <= e.b;
            end else if (md_wr) begin
                md_busy_q <= 1'b0;
            end else if (md_busy_q && md_cnt_q != 2'd0) begin
                md_cnt_q <= md_cnt_q - 2'd1;
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
            e.ALU_S <= bubble ? '0 : alu;
            e.MemWriteData <= bubble ? '0 : e.mem_wdata_in;
            e.WriteReg <= bubble ? '0 : e.wreg_in;
            e.MemRead <= bubble ? BUBBLE_MEM_READ : e.mem_read_in;
            e.MemWrite <= bubble ? BUBBLE_MEM_WRITE : e.mem_write_in;
            e.RegWrite <= bubble ? BUBBLE_REG_WRITE : e.reg_write_in;
            e.MemToReg <= bubble ? '0 : e.mem_to_reg_in;
            e.PC_Plus4 <= bubble ? '0 : e.pc_plus4_in;
            e.LUOp <= bubble ? 1'b0 : e.lu_op_in;
            e.LUData <= bubble ? '0 : e.imm_lu;
        end
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, multiply latency in cycles (range 1..4).
REQ-002 SHALL have ports: clk in 1, pipeline clock; reset in 1, asynchronous active-high reset.
REQ-003 SHALL have inputs: in_valid 1; flush 1, kill the current EX instruction; op 5, ex_pkg opcode; a 32 and b 32, forwarded operands; shamt 5; imm_lu 32, pre-shifted LUI value.
REQ-004 SHALL have pass-through inputs: mem_wdata_in 32, wreg_in 5, mem_read_in 1, mem_write_in 1, reg_write_in 1, mem_to_reg_in 2, pc_plus4_in 32, lu_op_in 1.
REQ-005 SHALL have registered outputs: ALU_S 32, MemWriteData 32, WriteReg 5, MemRead 1, MemWrite 1, RegWrite 1, MemToReg 2, PC_Plus4 32, LUOp 1, LUData 32; these feed MEM directly.
REQ-006 SHALL have outputs stall 1, hold the upstream stage; md_busy 1, multiply/divide in flight.

Function
REQ-007 SHALL compute ADD, SUB (wrap, no overflow trap), AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA by shamt, SLLV/SRLV/SRAV by b[4:0], in one cycle.
REQ-008 SHALL implement HI/LO registers; MFHI/MFLO return them on ALU_S; MTHI/MTLO write a into them at the capture edge.
REQ-009 SHALL accept MULT/MULTU/DIV/DIVU when in_valid & ~flush & ~md_busy, set md_busy the next cycle, and pass a bubble (RegWrite=MemRead=MemWrite=0) to the EX/MEM register.
REQ-010 SHALL write the 64-bit product to {HI,LO} exactly MUL_LAT cycles after acceptance and then clear md_busy.
REQ-011 SHALL divide with radix-2 restoring iteration on magnitudes, writing quotient to LO and remainder to HI 33 cycles after acceptance; remainder takes the dividend's sign.
REQ-012 SHALL on divide-by-zero produce LO=0xFFFFFFFF, HI=dividend; on signed 0x80000000/-1 produce LO=0x80000000, HI=0.
REQ-013 SHALL assert stall combinationally iff md_busy & in_valid & op is MFHI/MFLO/MTHI/MTLO/MULT*/DIV*; all other ops proceed while busy.
REQ-014 SHALL, while stall=1, load a bubble into the EX/MEM register and not consume the held instruction.
REQ-015 SHALL load a bubble when in_valid=0 or flush=1; flush does not abort an accepted multiply/divide.
REQ-016 SHALL, when an MD completion and an MTHI/MTLO coincide, give completion priority (MT* is stalled anyway per REQ-013).
REQ-017 SHALL register all non-bubble pass-through fields unchanged; ALU_S carries the ALU/HI/LO result.

Reset
REQ-018 SHALL, on reset, asynchronously clear every registered output, HI, LO, md_busy and the divider/multiplier state; an operation in flight is discarded.
REQ-019 SHALL resume accepting on the first clk edge after reset deasserts.

Configuration
REQ-020 SHALL, with EX_DIV_EN defined, implement DIV/DIVU per REQ-011/012.
REQ-021 SHALL, without EX_DIV_EN, treat DIV/DIVU as no-ops: bubble to EX/MEM, HI/LO unchanged, md_busy never set by them.

Structure
REQ-022 SHALL place the opcode enum, MD_DIV_CYCLES=33 and the bubble field values in package ex_pkg.
REQ-023 SHALL isolate the iterative divider in sub-module ex_divider (start/done handshake, signed flag), instantiated only under EX_DIV_EN.

Verification
REQ-024 ADD a=0x7FFFFFFF b=1 -> ALU_S=0x80000000, RegWrite=1 one cycle later.
REQ-025 MULT a=-3 b=5 then MFLO next cycle -> stall=1 for MUL_LAT cycles, then ALU_S=0xFFFFFFF1; MFHI -> 0xFFFFFFFF.
REQ-026 DIV a=-7 b=2 -> after 33 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; ADD issued during busy completes without stall.
REQ-027 DIVU a=5 b=0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-028 Reset asserted mid-DIV at cycle 10 -> all outputs, HI, LO, md_busy read 0 immediately; a following MFLO returns 0 with no stall.
REQ-029 flush=1 with SW in EX -> MemWrite=0 next cycle; flush during busy MULT -> HI/LO still updated.
